// File: rtl/pass_entry_pkg.sv
// rtl/pass_entry_pkg.sv - shared types and codes for the pass_entry front end
package pass_entry_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [2:0] {
        ENT_IDLE   = 3'b000,
        ENT_ENTRY  = 3'b001,
        ENT_WAIT   = 3'b010,
        ENT_ENTRY2 = 3'b011,
        ENT_DONE   = 3'b100,
        ENT_LOCK   = 3'b101
    } ent_state_t;

    localparam logic [2:0] ST_REQUEST = 3'b101;
    localparam logic [2:0] ST_TRAP    = 3'b111;
    localparam logic [2:0] ST_SAVE    = 3'b110;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_START,
        KEY_BIT0,
        KEY_BIT1,
        KEY_ENTER,
        KEY_CANCEL
    } key_t;

    // Only one press acts per cycle; cancel beats everything, start loses to all.
    function automatic key_t key_win(input logic cancel, input logic enter,
                                     input logic bit1, input logic bit0,
                                     input logic start);
        if (cancel) return KEY_CANCEL;
        if (enter)  return KEY_ENTER;
        if (bit1)   return KEY_BIT1;
        if (bit0)   return KEY_BIT0;
        if (start)  return KEY_START;
        return KEY_NONE;
    endfunction

endpackage

// File: rtl/pass_entry_key_debounce.sv
// rtl/pass_entry_key_debounce.sv - button synchroniser, debouncer and press pulse
module key_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          prev_q, press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips only after DEB_CYCLES consecutive cycles of disagreement.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= key_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/pass_entry.sv
// rtl/pass_entry.sv - button-driven code entry front end for the lock FSM
module pass_entry
    import pass_entry_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int LOCK_CYCLES = 16,
    parameter int MAX_FAIL    = 3,
    parameter int WAIT_TMO    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_start,
    input  logic        key_bit0,
    input  logic        key_bit1,
    input  logic        key_enter,
    input  logic        key_cancel,
    input  logic [2:0]  fsm_state,
    output logic        rqst,
    output logic        confirm,
    output logic [3:0]  pass_data,
    output logic [2:0]  bit_cnt,
    output logic        locked,
    output logic        err,
    output logic [2:0]  ent_state
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int TW = $clog2(WAIT_TMO + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic p_start, p_bit0, p_bit1, p_enter, p_cancel;
    key_t win;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start  (.clk(clk), .rst(rst), .key_i(key_start),  .press_o(p_start));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_bit0   (.clk(clk), .rst(rst), .key_i(key_bit0),   .press_o(p_bit0));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_bit1   (.clk(clk), .rst(rst), .key_i(key_bit1),   .press_o(p_bit1));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter  (.clk(clk), .rst(rst), .key_i(key_enter),  .press_o(p_enter));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cancel (.clk(clk), .rst(rst), .key_i(key_cancel), .press_o(p_cancel));

    assign win = key_win(p_cancel, p_enter, p_bit1, p_bit0, p_start);

    ent_state_t        state_q, state_d;
    logic [CODE_W-1:0] sr_q, sr_d, pass_q, pass_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic [LW-1:0]     lock_q, lock_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              confirm_q, confirm_d, err_q, err_d;
    logic              rqst_q, rqst_d, locked_q, locked_d;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        lock_d    = '0;
        tmo_d     = '0;
        confirm_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ENT_IDLE: begin
                if (win == KEY_START) begin
                    state_d = ENT_ENTRY;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
            ENT_ENTRY, ENT_ENTRY2: begin
                case (win)
                    KEY_CANCEL: state_d = ENT_IDLE;
                    KEY_BIT0, KEY_BIT1: begin
                        if (cnt_q < 3'(CODE_W)) begin
                            sr_d  = {sr_q[CODE_W-2:0], win == KEY_BIT1};
                            cnt_d = cnt_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    KEY_ENTER: begin
                        if (cnt_q == 3'(CODE_W)) begin
                            pass_d    = sr_q;
                            confirm_d = 1'b1;
                            state_d   = (state_q == ENT_ENTRY) ? ENT_WAIT : ENT_DONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ENT_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // First WAIT cycle is the confirm cycle; downstream answers from the next one.
                if (win == KEY_CANCEL) begin
                    state_d = ENT_IDLE;
                end else if (tmo_q != '0 && fsm_state == ST_REQUEST) begin
                    fail_d  = '0;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = ENT_ENTRY2;
                end else if (tmo_q != '0 && fsm_state == ST_TRAP) begin
                    fail_d  = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;
                    state_d = (fail_d == FW'(MAX_FAIL)) ? ENT_LOCK : ENT_IDLE;
                end else if (tmo_q == TW'(WAIT_TMO)) begin
                    err_d   = 1'b1;
                    state_d = ENT_IDLE;
                end
            end
            ENT_DONE: begin
                if (win == KEY_CANCEL) state_d = ENT_IDLE;
            end
            ENT_LOCK: begin
                lock_d = lock_q + 1'b1;
                if (lock_q == LW'(LOCK_CYCLES - 1)) begin
                    lock_d  = '0;
                    fail_d  = '0;
                    state_d = ENT_IDLE;
                end
            end
            default: state_d = ENT_IDLE;
        endcase
        rqst_d   = (state_d == ENT_ENTRY) || (state_d == ENT_WAIT) ||
                   (state_d == ENT_ENTRY2) || (state_d == ENT_DONE);
        locked_d = (state_d == ENT_LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ENT_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            lock_q    <= '0;
            tmo_q     <= '0;
            confirm_q <= 1'b0;
            err_q     <= 1'b0;
            rqst_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            lock_q    <= lock_d;
            tmo_q     <= tmo_d;
            confirm_q <= confirm_d;
            err_q     <= err_d;
            rqst_q    <= rqst_d;
            locked_q  <= locked_d;
        end
    end

    assign rqst      = rqst_q;
    assign confirm   = confirm_q;
    assign pass_data = pass_q;
    assign bit_cnt   = cnt_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign ent_state = state_q;

endmodule

// File: tb/tb_pass_entry.sv
// tb/tb_pass_entry.sv - randomized self-checking bench for pass_entry
module tb_pass_entry;

    localparam int DEB   = 4;
    localparam int LOCKC = 16;
    localparam int MAXF  = 3;
    localparam int TMO   = 8;

    localparam int S_IDLE = 0, S_ENTRY = 1, S_WAIT = 2, S_ENTRY2 = 3, S_DONE = 4, S_LOCK = 5;
    localparam int K_START = 0, K_B0 = 1, K_B1 = 2, K_ENTER = 3, K_CANCEL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start = 1'b0, key_bit0 = 1'b0, key_bit1 = 1'b0;
    logic       key_enter = 1'b0, key_cancel = 1'b0;
    logic [2:0] fsm_state = 3'b000;
    logic       rqst, confirm, locked, err;
    logic [3:0] pass_data;
    logic [2:0] bit_cnt, ent_state;

    pass_entry #(.DEB_CYCLES(DEB), .LOCK_CYCLES(LOCKC), .MAX_FAIL(MAXF), .WAIT_TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .key_start(key_start), .key_bit0(key_bit0), .key_bit1(key_bit1),
        .key_enter(key_enter), .key_cancel(key_cancel),
        .fsm_state(fsm_state),
        .rqst(rqst), .confirm(confirm), .pass_data(pass_data), .bit_cnt(bit_cnt),
        .locked(locked), .err(err), .ent_state(ent_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse monitors
    int   conf_pulses = 0, conf_hi = 0, err_pulses = 0, err_hi = 0, lock_hi = 0;
    logic conf_prev = 1'b0, err_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            conf_prev = 1'b0;
            err_prev  = 1'b0;
        end else begin
            if (confirm) conf_hi++;
            if (confirm && !conf_prev) conf_pulses++;
            if (err) err_hi++;
            if (err && !err_prev) err_pulses++;
            if (locked) lock_hi++;
            conf_prev = confirm;
            err_prev  = err;
        end
    end

    // Reference model: abstract entry state, code, failures, event counts
    int         ms = S_IDLE, mcnt = 0, mfail = 0, mconf = 0, merr = 0;
    logic [3:0] msr = 4'h0, mpass = 4'h0;

    task automatic model_reset();
        ms = S_IDLE; mcnt = 0; mfail = 0; msr = 4'h0; mpass = 4'h0;
    endtask

    task automatic resolve_wait();
        if (fsm_state == 3'b101) begin
            mfail = 0; msr = 4'h0; mcnt = 0; ms = S_ENTRY2;
        end else if (fsm_state == 3'b111) begin
            if (mfail < MAXF) mfail++;
            ms = (mfail == MAXF) ? S_LOCK : S_IDLE;
        end else begin
            merr++;
            ms = S_IDLE;
        end
    endtask

    task automatic model_press(input int k);
        if (ms == S_LOCK) begin
            ms = S_IDLE;
            mfail = 0;
        end
        case (ms)
            S_IDLE: if (k == K_START) begin ms = S_ENTRY; msr = 4'h0; mcnt = 0; end
            S_ENTRY, S_ENTRY2: begin
                if (k == K_CANCEL) ms = S_IDLE;
                else if (k == K_B0 || k == K_B1) begin
                    if (mcnt < 4) begin msr = {msr[2:0], k == K_B1}; mcnt++; end
                    else merr++;
                end else if (k == K_ENTER) begin
                    if (mcnt == 4) begin
                        mpass = msr;
                        mconf++;
                        if (ms == S_ENTRY2) ms = S_DONE;
                        else resolve_wait();
                    end else merr++;
                end
            end
            S_DONE: if (k == K_CANCEL) ms = S_IDLE;
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".state"}, ent_state, ms);
        check_eq({tag, ".rqst"}, rqst, (ms == S_ENTRY || ms == S_ENTRY2 || ms == S_DONE || ms == S_WAIT));
        check_eq({tag, ".locked"}, locked, ms == S_LOCK);
        check_eq({tag, ".bit_cnt"}, bit_cnt, mcnt);
        check_eq({tag, ".pass"}, pass_data, mpass);
        check_eq({tag, ".confirms"}, conf_pulses, mconf);
        check_eq({tag, ".errs"}, err_pulses, merr);
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_START:  key_start  = v;
            K_B0:     key_bit0   = v;
            K_B1:     key_bit1   = v;
            K_ENTER:  key_enter  = v;
            default:  key_cancel = v;
        endcase
    endtask

    // Returns just after the edge on which the FSM acts on the press.
    task automatic press(input int k);
        repeat (DEB + 4) @(posedge clk);
        #1 set_key(k, 1'b1);
        repeat (DEB + 4) @(posedge clk);
        #1 set_key(k, 1'b0);
    endtask

    task automatic step(input int k, input string tag);
        model_press(k);
        press(k);
        repeat (12) @(posedge clk);
        #1 check_model(tag);
    endtask

    task automatic enter_code(input logic [3:0] code, input string tag);
        for (int i = 3; i >= 0; i--) step(code[i] ? K_B1 : K_B0, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r;
        logic [3:0] code;
        int lk0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.state", ent_state, 0);
        check_eq("rst.rqst", rqst, 0);
        check_eq("rst.confirm", confirm, 0);
        check_eq("rst.err", err, 0);
        check_eq("rst.locked", locked, 0);
        check_eq("rst.pass", pass_data, 0);
        check_eq("rst.bit_cnt", bit_cnt, 0);
        rst = 1'b0;
        model_reset();

        // Happy path, with exact press and confirm latency checks
        fsm_state = 3'b101;
        model_press(K_START);
        press(K_START);
        check_eq("start_lat.rqst", rqst, 1);
        check_eq("start_lat.state", ent_state, S_ENTRY);
        repeat (12) @(posedge clk);
        enter_code(4'b1111, "hp1");
        model_press(K_ENTER);
        press(K_ENTER);
        check_eq("hp.confirm_n1", confirm, 1);
        check_eq("hp.pass_n1", pass_data, 4'b1111);
        @(posedge clk);
        #1 check_eq("hp.confirm_n2", confirm, 0);
        repeat (11) @(posedge clk);
        #1 check_model("hp.wait");
        enter_code(4'b0110, "hp2");
        step(K_ENTER, "hp.done");
        step(K_CANCEL, "hp.cancel");

        // Lockout after three traps; start during lock is ignored
        fsm_state = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step(K_START, "lk.start");
            enter_code(4'b1010, "lk.code");
            if (i < 2) step(K_ENTER, "lk.trap");
        end
        model_press(K_ENTER);
        lk0 = lock_hi;
        press(K_ENTER);
        key_start = 1'b1;
        repeat (11) @(posedge clk);
        #1 check_model("lk.locked");
        key_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        ms = S_IDLE;
        mfail = 0;
        check_model("lk.after");
        check_eq("lk.length", lock_hi - lk0, LOCKC);
        step(K_START, "lk.s2");
        enter_code(4'b0001, "lk.c2");
        step(K_ENTER, "lk.one_trap");

        // Entry errors and bounce
        step(K_START, "ee.start");
        step(K_B1, "ee.b"); step(K_B0, "ee.b"); step(K_B1, "ee.b");
        step(K_ENTER, "ee.short_enter");
        repeat (DEB + 4) @(posedge clk);
        #1 key_bit1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 key_bit1 = 1'b0;
        repeat (12) @(posedge clk);
        #1 check_model("ee.bounce");
        step(K_B0, "ee.b4");
        step(K_B1, "ee.b5");

        // Cancel and enter in the same debounced cycle
        repeat (DEB + 4) @(posedge clk);
        #1 begin key_cancel = 1'b1; key_enter = 1'b1; end
        repeat (DEB + 4) @(posedge clk);
        #1 begin key_cancel = 1'b0; key_enter = 1'b0; end
        ms = S_IDLE;
        repeat (12) @(posedge clk);
        #1 check_model("sim.cancel_enter");

        // Downstream never answers
        fsm_state = 3'b001;
        step(K_START, "to.start");
        enter_code(4'($urandom), "to.code");
        step(K_ENTER, "to.timeout");

        // Reset during lock (one trap already counted)
        fsm_state = 3'b111;
        for (int i = 0; i < 2; i++) begin
            step(K_START, "rl.start");
            enter_code(4'b1100, "rl.code");
            step(K_ENTER, "rl.trap");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rl.state", ent_state, 0);
        check_eq("rl.rqst", rqst, 0);
        check_eq("rl.locked", locked, 0);
        check_eq("rl.pass", pass_data, 0);
        check_eq("rl.bit_cnt", bit_cnt, 0);
        check_eq("rl.confirm", confirm, 0);
        check_eq("rl.err", err, 0);
        rst = 1'b0;
        model_reset();
        step(K_START, "rl.s");
        enter_code(4'b0011, "rl.c");
        step(K_ENTER, "rl.trap_after_reset");

        // Randomized sequences
        for (int n = 0; n < 45; n++) begin
            r = $urandom_range(0, 9);
            fsm_state = (r < 5) ? 3'b101 : (r < 8) ? 3'b111 : 3'b001;
            r = $urandom_range(0, 99);
            if (ms == S_IDLE || ms == S_LOCK) k = (r < 85) ? K_START : $urandom_range(1, 4);
            else if (ms == S_DONE) k = (r < 40) ? K_CANCEL : $urandom_range(0, 3);
            else if (r < 6) k = K_CANCEL;
            else if (mcnt < 4 && r < 80) k = $urandom_range(1, 2);
            else if (r < 92) k = K_ENTER;
            else k = $urandom_range(0, 2);
            step(k, "rnd");
        end

        check_eq("confirm_width", conf_hi, conf_pulses);
        check_eq("err_width", err_hi, err_pulses);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
